// File: rtl/pos_dac_tx.sv
// pos_dac_tx: serialises the 16-bit position-loop DAC code as a 24-bit
// {command, code} SPI-style frame. Frames are sent on a code change or a
// forced update. A minimum sync_n high gap is enforced between frames.
module pos_dac_tx #(
  parameter int          CLK_DIV  = 2,
  parameter int          HOLD_CYC = 4,
  parameter logic [7:0]  DAC_CMD  = 8'h00
) (
  input  logic        clk_dac,
  input  logic        sys_rstn,
  input  logic        dac_enable,
  input  logic [15:0] pos_dac,
  input  logic        force_update,
  output logic        dac_sync_n,
  output logic        dac_sclk,
  output logic        dac_din,
  output logic        dac_busy,
  output logic        dac_done,
  output logic [15:0] dac_frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_TAIL,
    S_HOLD
  } state_t;

  // Down-counter reload values; a phase ends when the counter reaches zero.
  localparam logic [7:0] DIV_LD  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYC - 1);

  state_t      r_state,     w_state_next;
  logic [7:0]  r_div_cnt,   w_div_cnt_next;
  logic [4:0]  r_bit_cnt,   w_bit_cnt_next;
  logic [23:0] r_frame,     w_frame_next;
  logic [15:0] r_last_sent, w_last_sent_next;
  logic        r_pending,   w_pending_next;
  logic        r_sync_n,    w_sync_n_next;
  logic        r_sclk,      w_sclk_next;
  logic        r_din,       w_din_next;
  logic        r_busy,      w_busy_next;
  logic        r_done,      w_done_next;
  logic [15:0] r_frame_cnt, w_frame_cnt_next;

  logic        w_code_diff;
  logic        w_req;
  logic [4:0]  w_bit_dn;

  // Next-state and output logic; every output is registered so the
  // serial pins are glitch-free.
  always_comb begin
    w_state_next     = r_state;
    w_div_cnt_next   = r_div_cnt;
    w_bit_cnt_next   = r_bit_cnt;
    w_frame_next     = r_frame;
    w_last_sent_next = r_last_sent;
    w_sync_n_next    = r_sync_n;
    w_sclk_next      = r_sclk;
    w_din_next       = r_din;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_frame_cnt_next = r_frame_cnt;
    w_bit_dn         = r_bit_cnt - 5'd1;

    w_code_diff = (pos_dac != r_last_sent);
    w_req       = dac_enable && (r_pending || w_code_diff);

    // A strobe or a code change seen while a frame is in flight is remembered
    // so that one more frame follows; the in-flight frame is never altered.
    w_pending_next = r_pending | force_update | (r_busy & w_code_diff);

    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_next     = S_SETUP;
          w_frame_next     = {DAC_CMD, pos_dac};
          w_last_sent_next = pos_dac;
          // A strobe coincident with acceptance still earns an extra frame.
          w_pending_next   = force_update;
          w_sync_n_next    = 1'b0;
          w_din_next       = DAC_CMD[7];
          w_busy_next      = 1'b1;
          w_div_cnt_next   = DIV_LD;
        end
      end

      S_SETUP: begin
        if (r_div_cnt == 8'd0) begin
          // First rising edge carries bit 23, already on din.
          w_state_next   = S_SHIFT;
          w_sclk_next    = 1'b1;
          w_bit_cnt_next = 5'd23;
          w_div_cnt_next = DIV_LD;
        end else begin
          w_div_cnt_next = r_div_cnt - 8'd1;
        end
      end

      S_SHIFT: begin
        if (r_div_cnt != 8'd0) begin
          w_div_cnt_next = r_div_cnt - 8'd1;
        end else if (r_sclk) begin
          // Falling edge: the DAC samples din here.
          w_sclk_next    = 1'b0;
          w_div_cnt_next = DIV_LD;
        end else if (r_bit_cnt == 5'd0) begin
          w_state_next   = S_TAIL;
          w_div_cnt_next = DIV_LD;
        end else begin
          // Rising edge for the next bit: din moves together with sclk.
          w_sclk_next    = 1'b1;
          w_bit_cnt_next = w_bit_dn;
          w_din_next     = r_frame[w_bit_dn];
          w_div_cnt_next = DIV_LD;
        end
      end

      S_TAIL: begin
        if (r_div_cnt == 8'd0) begin
          w_state_next     = S_HOLD;
          w_sync_n_next    = 1'b1;
          w_din_next       = 1'b0;
          w_done_next      = 1'b1;
          w_frame_cnt_next = r_frame_cnt + 16'd1;
          w_div_cnt_next   = HOLD_LD;
        end else begin
          w_div_cnt_next = r_div_cnt - 8'd1;
        end
      end

      S_HOLD: begin
        if (r_div_cnt == 8'd0) begin
          w_state_next = S_IDLE;
          w_busy_next  = 1'b0;
        end else begin
          w_div_cnt_next = r_div_cnt - 8'd1;
        end
      end

      default: begin
        w_state_next  = S_IDLE;
        w_sync_n_next = 1'b1;
        w_sclk_next   = 1'b0;
        w_din_next    = 1'b0;
        w_busy_next   = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any frame at once and arms a power-up frame.
  always_ff @(posedge clk_dac or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_state     <= S_IDLE;
      r_div_cnt   <= 8'd0;
      r_bit_cnt   <= 5'd0;
      r_frame     <= 24'd0;
      r_last_sent <= 16'h8000;
      r_pending   <= 1'b1;
      r_sync_n    <= 1'b1;
      r_sclk      <= 1'b0;
      r_din       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_next;
      r_div_cnt   <= w_div_cnt_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_frame     <= w_frame_next;
      r_last_sent <= w_last_sent_next;
      r_pending   <= w_pending_next;
      r_sync_n    <= w_sync_n_next;
      r_sclk      <= w_sclk_next;
      r_din       <= w_din_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_frame_cnt <= w_frame_cnt_next;
    end
  end

  assign dac_sync_n    = r_sync_n;
  assign dac_sclk      = r_sclk;
  assign dac_din       = r_din;
  assign dac_busy      = r_busy;
  assign dac_done      = r_done;
  assign dac_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_pos_dac_tx.sv
// Directed bench for pos_dac_tx: one instance at CLK_DIV=2 for most
// scenarios, one at CLK_DIV=3 for the slow-clock waveform check.
module tb_pos_dac_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, frc, en3, frc3;
  logic [15:0] pos, pos3;
  logic        sync_n, sclk, din, busy, done;
  logic [15:0] cnt;
  logic        sync3_n, sclk3, din3, busy3, done3;
  logic [15:0] cnt3;
  logic        sel3;
  logic        m_sync, m_sclk, m_din, m_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pos_dac_tx #(.CLK_DIV(2), .HOLD_CYC(4), .DAC_CMD(8'h00)) dut (
    .clk_dac(clk), .sys_rstn(rst_n), .dac_enable(en), .pos_dac(pos),
    .force_update(frc), .dac_sync_n(sync_n), .dac_sclk(sclk), .dac_din(din),
    .dac_busy(busy), .dac_done(done), .dac_frame_cnt(cnt)
  );

  pos_dac_tx #(.CLK_DIV(3), .HOLD_CYC(4), .DAC_CMD(8'h00)) dut3 (
    .clk_dac(clk), .sys_rstn(rst_n), .dac_enable(en3), .pos_dac(pos3),
    .force_update(frc3), .dac_sync_n(sync3_n), .dac_sclk(sclk3), .dac_din(din3),
    .dac_busy(busy3), .dac_done(done3), .dac_frame_cnt(cnt3)
  );

  assign m_sync = sel3 ? sync3_n : sync_n;
  assign m_sclk = sel3 ? sclk3   : sclk;
  assign m_din  = sel3 ? din3    : din;
  assign m_done = sel3 ? done3   : done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for sync_n low, then follows the frame until dac_done. Returns the
  // word shifted in on falling edges, the done cycle index (cycle 1 = first
  // sync_n-low cycle), the sclk pulse count and a count of waveform faults
  // (wrong half-period, din moving outside a rising-edge cycle, early sync_n).
  task automatic grab(input int cd, output logic [23:0] word, output int len,
                      output int pulses, output int bad);
    int guard;
    int lo_run;
    int hi_run;
    logic ps, pd;
    word = 24'd0; len = 0; pulses = 0; bad = 0; guard = 0;
    while (m_sync !== 1'b0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (m_sync !== 1'b0) begin
      chk("frame_start_timeout", {31'd0, m_sync}, 32'd0);
      return;
    end
    len = 1;
    ps = m_sclk; pd = m_din;
    lo_run = ps ? 0 : 1;
    hi_run = ps ? 1 : 0;
    guard = 0;
    while (guard < 3000) begin
      @(negedge clk);
      guard++;
      len++;
      if (m_done) break;
      if (ps && !m_sclk) begin
        pulses++;
        word = {word[22:0], pd};
        if (hi_run != cd) bad++;
        lo_run = 1; hi_run = 0;
      end else if (!ps && m_sclk) begin
        if (lo_run != cd) bad++;
        hi_run = 1; lo_run = 0;
      end else if (m_sclk) begin
        hi_run++;
      end else begin
        lo_run++;
      end
      if (m_din !== pd && !(!ps && m_sclk)) bad++;
      if (m_sync !== 1'b0) bad++;
      ps = m_sclk; pd = m_din;
    end
    if (m_done !== 1'b1) chk("frame_done_timeout", {31'd0, m_done}, 32'd1);
    $display("frame: word=%06h done_cycle=%0d pulses=%0d faults=%0d", word, len, pulses, bad);
  endtask

  initial begin
    logic [23:0] w;
    int len, pul, bad, hi, guard;

    rst_n = 1'b0; en = 1'b1; pos = 16'h8000; frc = 1'b0;
    en3 = 1'b0; pos3 = 16'h8000; frc3 = 1'b0; sel3 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_sync_n", {31'd0, sync_n}, 32'd1);
    chk("rst_sclk",   {31'd0, sclk},   32'd0);
    chk("rst_din",    {31'd0, din},    32'd0);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_done",   {31'd0, done},   32'd0);
    chk("rst_cnt",    {16'd0, cnt},    32'd0);

    // Power-up frame at midscale
    rst_n = 1'b1;
    grab(2, w, len, pul, bad);
    chk("pwrup_word",   {8'd0, w}, 32'h008000);
    chk("pwrup_len",    len, 101);
    chk("pwrup_pulses", pul, 24);
    chk("pwrup_faults", bad, 0);
    chk("pwrup_cnt",    {16'd0, cnt}, 32'd1);
    chk("pwrup_busy",   {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    repeat (30) @(negedge clk);
    chk("idle_sync_n", {31'd0, sync_n}, 32'd1);
    chk("idle_busy",   {31'd0, busy},   32'd0);
    chk("idle_cnt",    {16'd0, cnt},    32'd1);

    // Code changes during a frame collapse into one follow-up frame
    pos = 16'h1234;
    repeat (3) @(negedge clk);
    pos = 16'h5678;
    repeat (10) @(negedge clk);
    pos = 16'h9ABC;
    grab(2, w, len, pul, bad);
    chk("chg_first_word", {8'd0, w}, 32'h001234);
    hi = 1; guard = 0;
    @(negedge clk);
    while (sync_n === 1'b1 && guard < 200) begin
      hi++; guard++;
      @(negedge clk);
    end
    chk("chg_gap", hi, 5);
    grab(2, w, len, pul, bad);
    chk("chg_second_word", {8'd0, w}, 32'h009ABC);
    chk("chg_second_len",  len, 101);
    repeat (150) @(negedge clk);
    chk("chg_cnt", {16'd0, cnt}, 32'd3);

    // Forced update with unchanged code
    pos = 16'h4000;
    grab(2, w, len, pul, bad);
    chk("f_word0", {8'd0, w}, 32'h004000);
    repeat (20) @(negedge clk);
    frc = 1'b1;
    @(negedge clk);
    frc = 1'b0;
    grab(2, w, len, pul, bad);
    chk("force_word",   {8'd0, w}, 32'h004000);
    chk("force_faults", bad, 0);
    repeat (150) @(negedge clk);
    chk("force_cnt", {16'd0, cnt}, 32'd5);

    // Strobe coincident with acceptance: two identical frames
    pos = 16'h4444; frc = 1'b1;
    @(negedge clk);
    frc = 1'b0;
    grab(2, w, len, pul, bad);
    chk("coinc_word1", {8'd0, w}, 32'h004444);
    grab(2, w, len, pul, bad);
    chk("coinc_word2", {8'd0, w}, 32'h004444);
    repeat (150) @(negedge clk);
    chk("coinc_cnt", {16'd0, cnt}, 32'd7);

    // Disabled: code change held until re-enabled
    en = 1'b0; pos = 16'h1111;
    repeat (40) @(negedge clk);
    chk("dis_sync_n", {31'd0, sync_n}, 32'd1);
    chk("dis_cnt",    {16'd0, cnt},    32'd7);
    en = 1'b1;
    grab(2, w, len, pul, bad);
    chk("reen_word", {8'd0, w}, 32'h001111);
    chk("reen_cnt",  {16'd0, cnt}, 32'd8);

    // Reset mid-frame around bit 10
    repeat (20) @(negedge clk);
    pos = 16'h2222;
    guard = 0;
    while (sync_n !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (55) @(negedge clk);
    chk("pre_rst_sync_n", {31'd0, sync_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_sync_n", {31'd0, sync_n}, 32'd1);
    chk("midrst_sclk",   {31'd0, sclk},   32'd0);
    chk("midrst_busy",   {31'd0, busy},   32'd0);
    @(negedge clk);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_cnt",  {16'd0, cnt},  32'd0);
    pos = 16'h8000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    grab(2, w, len, pul, bad);
    chk("post_rst_word", {8'd0, w}, 32'h008000);
    chk("post_rst_len",  len, 101);
    chk("post_rst_cnt",  {16'd0, cnt}, 32'd1);

    // Frame counter wrap
    repeat (20) @(negedge clk);
    force dut.r_frame_cnt = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.r_frame_cnt;
    @(negedge clk);
    chk("preload_cnt", {16'd0, cnt}, 32'h0000FFFF);
    pos = 16'h3333;
    grab(2, w, len, pul, bad);
    chk("wrap_word", {8'd0, w}, 32'h003333);
    chk("wrap_done", {31'd0, done}, 32'd1);
    chk("wrap_cnt",  {16'd0, cnt}, 32'd0);

    // CLK_DIV=3 instance: power-up frame, then A5C3
    sel3 = 1'b1; en3 = 1'b1;
    grab(3, w, len, pul, bad);
    chk("cd3_pwrup_word", {8'd0, w}, 32'h008000);
    repeat (30) @(negedge clk);
    pos3 = 16'hA5C3;
    grab(3, w, len, pul, bad);
    chk("cd3_word",   {8'd0, w}, 32'h00A5C3);
    chk("cd3_len",    len, 151);
    chk("cd3_pulses", pul, 24);
    chk("cd3_faults", bad, 0);
    chk("cd3_cnt",    {16'd0, cnt3}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pos_dac_tx.md
POS_DAC_TX -- requirements
Module: pos_dac_tx

Interface
REQ-001 Parameter CLK_DIV, default 2, SHALL set the SCLK half-period in clk_dac cycles; legal range 1..255.
REQ-002 Parameter HOLD_CYC, default 4, SHALL set the minimum dac_sync_n high time between frames in clk_dac cycles; legal range 1..255.
REQ-003 Parameter DAC_CMD, default 8'h00, SHALL be the 8-bit command prefix of every frame.
REQ-004 sys_rstn  input  1  SHALL be the asynchronous active-low reset.
REQ-005 clk_dac  input  1  SHALL be the single clock; all logic is rising-edge triggered.
REQ-006 dac_enable  input  1  SHALL, while high, permit new frames to start.
REQ-007 pos_dac  input  16  SHALL be the unsigned DAC code from the position loop (midscale 32768).
REQ-008 force_update  input  1  SHALL be a one-cycle strobe requesting a frame even if pos_dac is unchanged.
REQ-009 dac_sync_n  output  1  SHALL be the active-low frame select to the DAC.
REQ-010 dac_sclk  output  1  SHALL be the serial clock (idle low).
REQ-011 dac_din  output  1  SHALL be the serial data, MSB first.
REQ-012 dac_busy  output  1  SHALL be high from frame acceptance until the HOLD phase ends.
REQ-013 dac_done  output  1  SHALL pulse high for one cycle per completed frame.
REQ-014 dac_frame_cnt  output  16  SHALL count completed frames.

Function
REQ-015 Frame SHALL be 24 bits: {DAC_CMD, code}, where code is pos_dac sampled in the IDLE acceptance cycle.
REQ-016 FSM states SHALL be IDLE, SETUP, SHIFT, TAIL, HOLD.
REQ-017 Request SHALL exist when dac_enable=1 and (pending=1 or pos_dac != last_sent).
REQ-018 IDLE + request: next cycle SETUP, dac_sync_n=0, dac_din=frame[23], dac_busy=1, last_sent<=code, pending<=0.
REQ-019 SETUP SHALL last CLK_DIV cycles with dac_sclk=0, then enter SHIFT.
REQ-020 SHIFT: each bit SHALL take 2*CLK_DIV cycles, dac_sclk high for the first CLK_DIV, low for the second; the DAC samples on the falling edge.
REQ-021 dac_din SHALL change only in the cycle dac_sclk rises for the next bit (bit 22 down to bit 0); never while dac_sclk is high.
REQ-022 After the 24th falling edge, TAIL SHALL hold dac_sync_n=0, dac_sclk=0 for CLK_DIV cycles.
REQ-023 Leaving TAIL: dac_sync_n=1, dac_din=0, dac_done=1 for one cycle, dac_frame_cnt+1 (wrap 65535->0), enter HOLD.
REQ-024 HOLD SHALL last HOLD_CYC cycles, then dac_busy=0 and state IDLE; a request present in that IDLE cycle is accepted per REQ-018.
REQ-025 Frame length from acceptance edge to dac_done SHALL be 1 + CLK_DIV + 48*CLK_DIV + CLK_DIV cycles (101 at CLK_DIV=2).
REQ-026 force_update or any pos_dac change while busy SHALL set pending; pos_dac changes never alter the in-flight frame.
REQ-027 force_update coincident with acceptance SHALL leave pending=1 (one extra frame follows).
REQ-028 dac_enable falling mid-frame SHALL not abort the frame; pending and pos_dac comparison are held until re-enabled.
REQ-029 Back-to-back frames SHALL always show at least HOLD_CYC+1 cycles of dac_sync_n high.

Reset
REQ-030 While sys_rstn=0, asynchronously: state IDLE, dac_sync_n=1, dac_sclk=0, dac_din=0, dac_busy=0, dac_done=0, dac_frame_cnt=0, last_sent=32768, pending=1.
REQ-031 Reset asserted mid-frame SHALL terminate the frame immediately with no dac_done and no count increment.
REQ-032 After reset release with dac_enable=1, the first frame (pending=1) SHALL transmit the then-current pos_dac (midscale 32768 if loop is still in reset).

Verification
REQ-033 Release reset, dac_enable=1, pos_dac=16'h8000 -> one frame 24'h008000 on dac_din, dac_done at cycle 101 after acceptance, dac_frame_cnt=1, then idle.
REQ-034 pos_dac=16'hA5C3 after idle, CLK_DIV=3 -> 24 sclk pulses of 3 high/3 low, captured word 24'h00A5C3, dac_din stable across every falling edge.
REQ-035 pos_dac changes 16'h1234->16'h5678->16'h9ABC during a frame -> exactly one following frame carrying 16'h9ABC, sync_n high >= 5 cycles between frames.
REQ-036 force_update with unchanged pos_dac=16'h4000 -> one identical frame, count increments by 1.
REQ-037 sys_rstn low at bit 10 of a frame -> sync_n=1, sclk=0 same cycle, no dac_done, count=0; after release, midscale power-up frame sent.
REQ-038 Preload via 65535 completed frames then one more -> dac_frame_cnt wraps 65535->0 with dac_done pulse.
